// File: rtl/hall_commutator.sv
// hall_commutator: BLDC hall-sensor commutation unit.
// The raw hall code passes through a 2-FF synchroniser and a run-length deglitch filter.
// The accepted code is decoded to a sector and to phase drive (u) / high-Z (z) for either
// direction. The unit also tracks signed position, sequence jumps, invalid codes and stall.
// Optional build macro HALL_PERIOD_EN adds capture of the inter-transition period.
module hall_commutator #(
   parameter int FILTER_DEPTH = 4,
   parameter int COUNT_WIDTH  = 16,
   parameter int STALL_CYCLES = 50000,
   parameter int TIMER_WIDTH  = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [2:0]             h,
   input  logic                   enable,
   input  logic                   dir,
   input  logic                   fault_clear,
   output logic [2:0]             u,
   output logic [2:0]             z,
   output logic [2:0]             sector,
   output logic [COUNT_WIDTH-1:0] position,
   output logic                   seq_err,
   output logic                   hall_fault,
   output logic                   fault_latched,
   output logic                   stall,
   output logic [TIMER_WIDTH-1:0] period,
   output logic                   period_valid
);

   localparam int                     CNT_W       = $clog2(FILTER_DEPTH + 1);
   localparam logic [CNT_W-1:0]       CNT_FULL    = CNT_W'(FILTER_DEPTH);
   localparam logic [TIMER_WIDTH-1:0] TIMER_MAX   = TIMER_WIDTH'(STALL_CYCLES);
   localparam logic [2:0]             SECTOR_NONE = 3'd7;

   logic [2:0]             h_meta, h_sync, cand, stable;
   logic [CNT_W-1:0]       cnt;
   logic [2:0]             new_sector, u_fwd, z_map, u_next, z_next;
   logic [2:0]             sector_inc, sector_dec;
   logic                   sector_ok, moved, step_fwd, step_rev, counted, bad_jump, fault_next;
   logic [TIMER_WIDTH-1:0] timer, timer_inc;

   // Synchronise the pins and accept a code only after FILTER_DEPTH identical samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         h_meta <= 3'b000;
         h_sync <= 3'b000;
         cand   <= 3'b000;
         cnt    <= '0;
         stable <= 3'b000;
      end else begin
         // NOTE: non-blocking (<=) in clocked blocks so every flop sees pre-edge values
         // no matter how the statements are ordered.
         h_meta <= h;
         h_sync <= h_meta;
         if (h_sync != cand) begin
            cand <= h_sync;
            cnt  <= CNT_W'(1);
         end else if (cnt != CNT_FULL) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (cnt == CNT_FULL) stable <= cand;
      end
   end

   // Decode the accepted hall code to a sector and its forward drive pattern.
   always_comb begin
      // NOTE: every variable gets a default first so no branch leaves it unassigned,
      // which would otherwise infer a latch.
      new_sector = SECTOR_NONE;
      u_fwd      = 3'b000;
      z_map      = 3'b111;
      case (stable)
         3'b101:  begin new_sector = 3'd0; u_fwd = 3'b100; z_map = 3'b001; end
         3'b100:  begin new_sector = 3'd1; u_fwd = 3'b100; z_map = 3'b010; end
         3'b110:  begin new_sector = 3'd2; u_fwd = 3'b010; z_map = 3'b100; end
         3'b010:  begin new_sector = 3'd3; u_fwd = 3'b010; z_map = 3'b001; end
         3'b011:  begin new_sector = 3'd4; u_fwd = 3'b001; z_map = 3'b010; end
         3'b001:  begin new_sector = 3'd5; u_fwd = 3'b001; z_map = 3'b100; end
         default: ;
      endcase
   end

   // Phase drive: reverse swaps high and low sides; disabled or invalid floats all phases.
   always_comb begin
      sector_ok = (new_sector != SECTOR_NONE);
      u_next    = 3'b000;
      z_next    = 3'b111;
      if (enable && sector_ok) begin
         z_next = z_map;
         u_next = dir ? ~(u_fwd | z_map) : u_fwd;
      end
   end

   // Classify a change of sector against the previous one held in the sector register.
   always_comb begin
      sector_inc = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
      sector_dec = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
      moved      = sector_ok && (sector != SECTOR_NONE) && (new_sector != sector);
      step_fwd   = moved && (new_sector == sector_inc);
      step_rev   = moved && (new_sector == sector_dec);
      counted    = step_fwd || step_rev;
      bad_jump   = moved && !counted;
      fault_next = !sector_ok || bad_jump;
      timer_inc  = (timer == TIMER_MAX) ? timer : timer + TIMER_WIDTH'(1);
   end

   // Registered outputs, position counter, inter-transition timer and sticky fault.
   always_ff @(posedge clock) begin
      if (reset) begin
         u             <= 3'b000;
         z             <= 3'b111;
         sector        <= SECTOR_NONE;
         position      <= '0;
         seq_err       <= 1'b0;
         hall_fault    <= 1'b0;
         fault_latched <= 1'b0;
         timer         <= '0;
      end else begin
         u          <= u_next;
         z          <= z_next;
         sector     <= new_sector;
         seq_err    <= bad_jump;
         hall_fault <= !sector_ok;
         if (step_fwd)      position <= position + COUNT_WIDTH'(1);
         else if (step_rev) position <= position - COUNT_WIDTH'(1);
         timer <= counted ? '0 : timer_inc;
         if (fault_next)       fault_latched <= 1'b1;
         else if (fault_clear) fault_latched <= 1'b0;
      end
   end

   assign stall = (timer == TIMER_MAX);

`ifdef HALL_PERIOD_EN
   // Capture the length of the interval that closes on this counted transition.
   always_ff @(posedge clock) begin
      if (reset) begin
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= counted;
         if (counted) period <= timer_inc;
      end
   end
`else
   assign period       = '0;
   assign period_valid = 1'b0;
`endif

endmodule
